// File: rtl/insert_vlan_tag_from_tdest_pkg.sv
// rtl/insert_vlan_tag_from_tdest_pkg.sv - shared constants, FSM encoding and TPID helper
package insert_vlan_tag_from_tdest_pkg;

  localparam int          HDR_MAC_BYTES = 12;
  localparam logic [11:0] VID_DEFAULT   = 12'd1;

  localparam logic [7:0] TPID_8100_HI = 8'h81;
  localparam logic [7:0] TPID_9100_HI = 8'h91;
  localparam logic [7:0] TPID_LO      = 8'h00;

  typedef enum logic [3:0] {
    ST_HDR    = 4'd0,
    ST_CAP12  = 4'd1,
    ST_CAP13  = 4'd2,
    ST_INS0   = 4'd3,
    ST_INS1   = 4'd4,
    ST_INS2   = 4'd5,
    ST_INS3   = 4'd6,
    ST_EMIT12 = 4'd7,
    ST_EMIT13 = 4'd8,
    ST_PCP14  = 4'd9,
    ST_BODY   = 4'd10
  } state_t;

  function automatic logic is_vlan_tpid(input logic [7:0] hi, input logic [7:0] lo);
    return ((hi == TPID_8100_HI) || (hi == TPID_9100_HI)) && (lo == TPID_LO);
  endfunction

endpackage

// File: rtl/insert_vlan_tag_from_tdest_pcp_mapper.sv
// rtl/insert_vlan_tag_from_tdest_pcp_mapper.sv - 8:1 traffic-class to PCP select
module pcp_mapper (
  input  logic [2:0] pcp_mapper_0,
  input  logic [2:0] pcp_mapper_1,
  input  logic [2:0] pcp_mapper_2,
  input  logic [2:0] pcp_mapper_3,
  input  logic [2:0] pcp_mapper_4,
  input  logic [2:0] pcp_mapper_5,
  input  logic [2:0] pcp_mapper_6,
  input  logic [2:0] pcp_mapper_7,
  input  logic [2:0] tdest,
  output logic [2:0] pcp
);

  always_comb begin
    pcp = pcp_mapper_0;
    case (tdest)
      3'd0: pcp = pcp_mapper_0;
      3'd1: pcp = pcp_mapper_1;
      3'd2: pcp = pcp_mapper_2;
      3'd3: pcp = pcp_mapper_3;
      3'd4: pcp = pcp_mapper_4;
      3'd5: pcp = pcp_mapper_5;
      3'd6: pcp = pcp_mapper_6;
      default: pcp = pcp_mapper_7;
    endcase
  end

endmodule

// File: rtl/insert_vlan_tag_from_tdest.sv
// rtl/insert_vlan_tag_from_tdest.sv - egress 802.1Q tag insert / PCP rewrite keyed by tdest
module insert_vlan_tag_from_tdest
  import insert_vlan_tag_from_tdest_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  pcp_mapper_0,
  input  logic [2:0]  pcp_mapper_1,
  input  logic [2:0]  pcp_mapper_2,
  input  logic [2:0]  pcp_mapper_3,
  input  logic [2:0]  pcp_mapper_4,
  input  logic [2:0]  pcp_mapper_5,
  input  logic [2:0]  pcp_mapper_6,
  input  logic [2:0]  pcp_mapper_7,
  input  logic [11:0] vid,
  input  logic        insert_enable,
  input  logic        rewrite_enable,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [1:0]  s_axis_tuser,
  input  logic [2:0]  s_axis_tdest,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [1:0]  m_axis_tuser
);

  localparam logic [3:0] LAST_MAC_IDX = 4'(HDR_MAC_BYTES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  pcp_q, pcp_sel;
  logic [7:0]  d12_q, d13_q;
  logic [1:0]  u12_q, u13_q;
  logic        l12_q, l13_q;
  logic        tagged_q;
  logic        tag_now;

  pcp_mapper u_pcp_mapper (
    .pcp_mapper_0 (pcp_mapper_0),
    .pcp_mapper_1 (pcp_mapper_1),
    .pcp_mapper_2 (pcp_mapper_2),
    .pcp_mapper_3 (pcp_mapper_3),
    .pcp_mapper_4 (pcp_mapper_4),
    .pcp_mapper_5 (pcp_mapper_5),
    .pcp_mapper_6 (pcp_mapper_6),
    .pcp_mapper_7 (pcp_mapper_7),
    .tdest        (s_axis_tdest),
    .pcp          (pcp_sel)
  );

  // Byte 13 is judged from the held byte 12 and the live byte, before it is registered.
  assign tag_now = is_vlan_tpid(d12_q, s_axis_tdata);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 2'b00;
    case (state_q)
      ST_HDR: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready) begin
          if (s_axis_tlast) begin
            cnt_d = 4'd0;
          end else if (cnt_q == LAST_MAC_IDX) begin
            cnt_d   = 4'd0;
            state_d = ST_CAP12;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_CAP12: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) state_d = s_axis_tlast ? ST_EMIT12 : ST_CAP13;
      end
      ST_CAP13: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (!tag_now && !s_axis_tlast && insert_enable) state_d = ST_INS0;
          else                                            state_d = ST_EMIT12;
        end
      end
      ST_INS0: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = TPID_8100_HI;
        if (m_axis_tready) state_d = ST_INS1;
      end
      ST_INS1: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = TPID_LO;
        if (m_axis_tready) state_d = ST_INS2;
      end
      ST_INS2: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = {pcp_q, 1'b0, vid[11:8]};
        if (m_axis_tready) state_d = ST_INS3;
      end
      ST_INS3: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = vid[7:0];
        if (m_axis_tready) state_d = ST_EMIT12;
      end
      ST_EMIT12: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = d12_q;
        m_axis_tlast  = l12_q;
        m_axis_tuser  = u12_q;
        if (m_axis_tready) state_d = l12_q ? ST_HDR : ST_EMIT13;
      end
      ST_EMIT13: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = d13_q;
        m_axis_tlast  = l13_q;
        m_axis_tuser  = u13_q;
        if (m_axis_tready) begin
          if (l13_q)         state_d = ST_HDR;
          else if (tagged_q) state_d = ST_PCP14;
          else               state_d = ST_BODY;
        end
      end
      ST_PCP14: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = rewrite_enable ? {pcp_q, s_axis_tdata[4:0]} : s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready) state_d = s_axis_tlast ? ST_HDR : ST_BODY;
      end
      ST_BODY: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          state_d = ST_HDR;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_HDR;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_HDR;
      cnt_q    <= 4'd0;
      pcp_q    <= 3'd0;
      d12_q    <= 8'h00;
      d13_q    <= 8'h00;
      u12_q    <= 2'b00;
      u13_q    <= 2'b00;
      l12_q    <= 1'b0;
      l13_q    <= 1'b0;
      tagged_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_HDR && cnt_q == 4'd0 && s_axis_tvalid && m_axis_tready)
        pcp_q <= pcp_sel;
      if (state_q == ST_CAP12 && s_axis_tvalid) begin
        d12_q <= s_axis_tdata;
        u12_q <= s_axis_tuser;
        l12_q <= s_axis_tlast;
      end
      if (state_q == ST_CAP13 && s_axis_tvalid) begin
        d13_q    <= s_axis_tdata;
        u13_q    <= s_axis_tuser;
        l13_q    <= s_axis_tlast;
        tagged_q <= tag_now;
      end
    end
  end

endmodule
